// File: rtl/inv_share_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// inv_share_scheduler_pkg
// Shared constants and helpers for the masked-inversion scheduler.
//   SHARE_W : width of one Boolean share (GF(2^8) element)
//   RND_W   : fresh randomness consumed per inversion operation
//   wrap_inc: modulo-n increment used for the round-robin pointer
// -----------------------------------------------------------------------------
package inv_share_scheduler_pkg;

  localparam int SHARE_W = 8;
  localparam int RND_W   = 64;

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/inv_share_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a rotating priority pointer. Searches from the
// pointer upward (wrapping) for the first active request and grants it when
// en is high. After a grant the pointer moves one past the winner; otherwise
// it holds. No grant is ever produced while RST is high.
//   CLK, RST : clock, synchronous active-high reset (pointer -> 0)
//   req      : per-requester request vector
//   en       : grant enable (a fresh random word is available)
//   gnt      : one-hot grant (all zero when nothing is granted)
//   gnt_id   : index of the selected requester (meaningful when |gnt)
// -----------------------------------------------------------------------------
module rr_arbiter
  import inv_share_scheduler_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   req,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);

  logic [IDW-1:0] r_ptr;
  logic           w_found;
  logic           w_grant;
  logic [IDW-1:0] w_sel;
  logic [IDW-1:0] w_lane;
  int             w_idx;

  // First active request at or after the pointer, with wrap-around.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    w_idx   = 0;
    w_lane  = '0;
    for (int j = 0; j < N; j++) begin
      w_idx = int'(r_ptr) + j;
      if (w_idx >= N) w_idx = w_idx - N;
      w_lane = IDW'(w_idx);
      if (!w_found && req[w_lane]) begin
        w_found = 1'b1;
        w_sel   = w_lane;
      end
    end
  end

  assign w_grant = w_found & en & ~RST;
  assign gnt     = w_grant ? (N'(1) << w_sel) : '0;
  assign gnt_id  = w_sel;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= IDW'(wrap_inc(int'(w_sel), N));
    end
  end

endmodule

// File: rtl/inv_share_scheduler.sv
// -----------------------------------------------------------------------------
// inv_share_scheduler
// Shares one two-share-in / four-share-out masked GF(2^8) inversion core
// among N requesters. A round-robin arbiter picks one requester per cycle
// (only when a fresh random word is available), its shares and the random
// word are registered into the core, and a {valid,id} shift register follows
// each operation through the core's fixed LAT-stage pipeline so the result
// shares come back tagged with the owning requester.
//   CLK, RST            : clock, synchronous active-high reset
//   req_valid/req_ready : per-lane request / one-hot grant
//   req_in0, req_in1    : per-lane Boolean shares, lane i at [8i+7:8i]
//   rnd/rnd_valid/ready : fresh randomness handshake (consumed only on issue)
//   inv_in0/1, inv_r    : registered shares and randomness to the core
//   inv_out0..3         : core output shares
//   resp_valid/resp_id  : result strobe and owning requester
//   resp_out0..3        : result shares, zero when resp_valid is low
//   idle                : nothing in flight and nothing issuing this cycle
// -----------------------------------------------------------------------------
module inv_share_scheduler
  import inv_share_scheduler_pkg::*;
#(
  parameter int N   = 4,
  parameter int LAT = 2,
  parameter int IDW = $clog2(N)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         req_valid,
  input  logic [SHARE_W*N-1:0] req_in0,
  input  logic [SHARE_W*N-1:0] req_in1,
  output logic [N-1:0]         req_ready,
  input  logic [RND_W-1:0]     rnd,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  output logic [SHARE_W-1:0]   inv_in0,
  output logic [SHARE_W-1:0]   inv_in1,
  output logic [RND_W-1:0]     inv_r,
  input  logic [SHARE_W-1:0]   inv_out0,
  input  logic [SHARE_W-1:0]   inv_out1,
  input  logic [SHARE_W-1:0]   inv_out2,
  input  logic [SHARE_W-1:0]   inv_out3,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [SHARE_W-1:0]   resp_out0,
  output logic [SHARE_W-1:0]   resp_out1,
  output logic [SHARE_W-1:0]   resp_out2,
  output logic [SHARE_W-1:0]   resp_out3,
  output logic                 idle
);

  logic [N-1:0]         w_gnt;
  logic [IDW-1:0]       w_gnt_id;
  logic                 w_issue;
  logic [SHARE_W-1:0]   w_mux0;
  logic [SHARE_W-1:0]   w_mux1;

  logic [SHARE_W-1:0]   r_inv_in0_p0;
  logic [SHARE_W-1:0]   r_inv_in1_p0;
  logic [RND_W-1:0]     r_inv_r_p0;
  logic [LAT:0]         r_trk_vld;
  logic [IDW-1:0]       r_trk_id [LAT+1];

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_arb (
    .CLK    (CLK),
    .RST    (RST),
    .req    (req_valid),
    .en     (rnd_valid),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  assign w_issue   = |w_gnt;
  assign req_ready = w_gnt;
  assign rnd_ready = w_issue;

  // Separate one-hot AND-OR muxes per share: the in0 and in1 paths never
  // meet, so the two shares are never combined inside this block.
  always_comb begin
    w_mux0 = '0;
    w_mux1 = '0;
    for (int i = 0; i < N; i++) begin
      w_mux0 = w_mux0 | (req_in0[SHARE_W*i +: SHARE_W] & {SHARE_W{w_gnt[i]}});
      w_mux1 = w_mux1 | (req_in1[SHARE_W*i +: SHARE_W] & {SHARE_W{w_gnt[i]}});
    end
  end

  // Stage p0: issue register. Loads zero on every non-issue cycle so the core
  // never sees stale shares or a reused random word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_inv_in0_p0 <= '0;
      r_inv_in1_p0 <= '0;
      r_inv_r_p0   <= '0;
    end else begin
      r_inv_in0_p0 <= w_mux0;
      r_inv_in1_p0 <= w_mux1;
      r_inv_r_p0   <= rnd & {RND_W{w_issue}};
    end
  end

  assign inv_in0 = r_inv_in0_p0;
  assign inv_in1 = r_inv_in1_p0;
  assign inv_r   = r_inv_r_p0;

  // Tracking: entry j is valid during the (j+1)-th cycle after issue, so the
  // last entry lines up with the core output LAT cycles after the issue stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_trk_vld <= '0;
    end else begin
      r_trk_vld[0] <= w_issue;
      for (int j = 1; j <= LAT; j++) begin
        r_trk_vld[j] <= r_trk_vld[j-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    r_trk_id[0] <= w_gnt_id;
    for (int j = 1; j <= LAT; j++) begin
      r_trk_id[j] <= r_trk_id[j-1];
    end
  end

  assign resp_valid = r_trk_vld[LAT];
  assign resp_id    = r_trk_id[LAT] & {IDW{resp_valid}};
  assign resp_out0  = inv_out0 & {SHARE_W{resp_valid}};
  assign resp_out1  = inv_out1 & {SHARE_W{resp_valid}};
  assign resp_out2  = inv_out2 & {SHARE_W{resp_valid}};
  assign resp_out3  = inv_out3 & {SHARE_W{resp_valid}};
  assign idle       = ~(|r_trk_vld) & ~w_issue;

endmodule

// File: tb/tb_inv_share_scheduler.sv
module tb_inv_share_scheduler;

  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int IDW = 2;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_in0, req_in1;
  logic [N-1:0]   req_ready;
  logic [63:0]    rnd;
  logic           rnd_valid;
  logic           rnd_ready;
  logic [7:0]     inv_in0, inv_in1;
  logic [63:0]    inv_r;
  logic [7:0]     inv_out0, inv_out1, inv_out2, inv_out3;
  logic           resp_valid;
  logic [IDW-1:0] resp_id;
  logic [7:0]     resp_out0, resp_out1, resp_out2, resp_out3;
  logic           idle;

  always #5 CLK = ~CLK;

  inv_share_scheduler #(.N(N), .LAT(LAT), .IDW(IDW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_in0(req_in0), .req_in1(req_in1), .req_ready(req_ready),
    .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .inv_in0(inv_in0), .inv_in1(inv_in1), .inv_r(inv_r),
    .inv_out0(inv_out0), .inv_out1(inv_out1), .inv_out2(inv_out2), .inv_out3(inv_out3),
    .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_out0(resp_out0), .resp_out1(resp_out1), .resp_out2(resp_out2), .resp_out3(resp_out3),
    .idle(idle)
  );

  // Golden inversion core: GF(2^8) inverse (AES polynomial), LAT stages,
  // output masked into four shares with the low 24 bits of the random word.
  logic [7:0]  inv_tab [256];
  logic [7:0]  gc_inv  [LAT];
  logic [23:0] gc_r    [LAT];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  always @(posedge CLK) begin
    gc_inv[0] <= inv_tab[inv_in0 ^ inv_in1];
    gc_r[0]   <= inv_r[23:0];
    for (int j = 1; j < LAT; j++) begin
      gc_inv[j] <= gc_inv[j-1];
      gc_r[j]   <= gc_r[j-1];
    end
  end

  assign inv_out0 = gc_r[LAT-1][7:0];
  assign inv_out1 = gc_r[LAT-1][15:8];
  assign inv_out2 = gc_r[LAT-1][23:16];
  assign inv_out3 = gc_inv[LAT-1] ^ gc_r[LAT-1][7:0] ^ gc_r[LAT-1][15:8] ^ gc_r[LAT-1][23:16];

  // Scoreboard
  typedef struct {
    logic [IDW-1:0] id;
    logic [23:0]    r;
    logic [7:0]     inv;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_resp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (resp_valid === 1'b1) begin
      n_resp++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_resp: got id %0d with no expected response", resp_id);
      end else begin
        e = sb_q.pop_front();
        chk("resp", 64'({resp_id, resp_out0, resp_out1, resp_out2, resp_out3}),
            64'({e.id, e.r[7:0], e.r[15:8], e.r[23:16],
                 e.inv ^ e.r[7:0] ^ e.r[15:8] ^ e.r[23:16]}));
      end
    end
  end

  function automatic logic [8*N-1:0] lane(input int i, input logic [7:0] v);
    logic [8*N-1:0] t;
    t = '0;
    t[8*i +: 8] = v;
    return t;
  endfunction

  // One cycle: drive inputs, check the grant at mid-cycle, push the expected
  // response for the lane that should win, then advance past the edge.
  task automatic step(input logic [N-1:0] rv, input logic [8*N-1:0] s0,
                      input logic [8*N-1:0] s1, input logic [63:0] r,
                      input logic rvld, input logic [N-1:0] eg, input string nm);
    exp_t e;
    req_valid = rv; req_in0 = s0; req_in1 = s1; rnd = r; rnd_valid = rvld;
    @(negedge CLK);
    chk(nm, 64'({rnd_ready, req_ready}), 64'({|eg, eg}));
    for (int i = 0; i < N; i++) begin
      if (eg[i]) begin
        e.id  = IDW'(i);
        e.r   = r[23:0];
        e.inv = inv_tab[s0[8*i +: 8] ^ s1[8*i +: 8]];
        sb_q.push_back(e);
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    int base;
    inv_tab[0] = 8'h00;
    for (int x = 1; x < 256; x++)
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv_tab[x] = 8'(y);

    // Reset with requests and randomness present: nothing may be granted.
    RST = 1'b1; req_valid = '1; rnd_valid = 1'b1; rnd = '1;
    req_in0 = 32'h11223344; req_in1 = 32'h55667788;
    next_cycle();
    @(negedge CLK);
    chk("rst_ready", 64'({rnd_ready, req_ready}), 64'h0);
    chk("rst_idle", 64'(idle), 64'h1);
    chk("rst_resp", 64'({resp_valid, resp_id, resp_out0, resp_out1, resp_out2, resp_out3}), 64'h0);
    chk("rst_issue", 64'({inv_in0, inv_in1}), 64'h0);
    chk("rst_inv_r", inv_r, 64'h0);
    next_cycle();
    RST = 1'b0;

    // All lanes requesting continuously: strict rotation from lane 0.
    base = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) base = n_resp;
      step('1, 32'h0a0b0c0d ^ {4{8'(c * 17)}}, 32'h01020304 * (c + 1),
           {$urandom, $urandom}, 1'b1, N'(1) << (c % N), "rr_all");
    end
    for (int c = 0; c < 3; c++) step('0, '0, '0, '0, 1'b1, '0, "rr_drain");
    chk("rr_no_gap", 64'(n_resp - base), 64'd8);
    @(negedge CLK);
    chk("idle_after_rr", 64'(idle), 64'h1);
    next_cycle();

    // Single request on lane 2: shares 0x53/0x00, rnd = 1.
    step(4'b0100, lane(2, 8'h53), '0, 64'h1, 1'b1, 4'b0100, "t1_grant");
    req_valid = '0;
    @(negedge CLK);
    chk("t1_issue", 64'({inv_in0, inv_in1}), 64'h5300);
    chk("t1_inv_r", inv_r, 64'h1);
    chk("t1_early1", 64'(resp_valid), 64'h0);
    next_cycle();
    @(negedge CLK);
    chk("t1_early2", 64'(resp_valid), 64'h0);
    next_cycle();
    @(negedge CLK);
    chk("t1_resp", 64'({resp_valid, resp_id}), 64'({1'b1, 2'd2}));
    chk("t1_xor", 64'(resp_out0 ^ resp_out1 ^ resp_out2 ^ resp_out3), 64'hca);
    next_cycle();
    @(negedge CLK);
    chk("t1_after", 64'({resp_valid, resp_out0, resp_out1, resp_out2, resp_out3, idle}), 64'h1);
    next_cycle();

    // Pointer is now 3; a lone lane-1 grant moves it to 2, then lanes 1 and 3
    // contend: lane 3 wins first, lane 1 after the wrap.
    step(4'b0010, lane(1, 8'h21), lane(1, 8'h02), 64'h0123456789abcdef, 1'b1, 4'b0010, "ptr_to_2");
    step(4'b1010, lane(1, 8'h37) | lane(3, 8'hc4), lane(1, 8'h10) | lane(3, 8'h0f),
         64'hfedcba9876543210, 1'b1, 4'b1000, "wrap_first");
    step(4'b1010, lane(1, 8'h37) | lane(3, 8'hc4), lane(1, 8'h10) | lane(3, 8'h0f),
         64'h00000000a5a5a5a5, 1'b1, 4'b0010, "wrap_second");
    for (int c = 0; c < 3; c++) step('0, '0, '0, '0, 1'b1, '0, "drain");

    // No randomness for 5 cycles: no grant, nothing issued to the core.
    for (int c = 0; c < 5; c++) begin
      req_valid = '1; req_in0 = 32'hdeadbeef; req_in1 = 32'h12345678;
      rnd = 64'hffff_0000_ffff_0000; rnd_valid = 1'b0;
      @(negedge CLK);
      chk("norand_ready", 64'({rnd_ready, req_ready}), 64'h0);
      chk("norand_issue", 64'({inv_in0, inv_in1}) | inv_r, 64'h0);
      next_cycle();
    end
    step('1, 32'hdeadbeef, 32'h12345678, 64'h1111_2222_3333_4444, 1'b1, 4'b0100, "rand_back");

    // Lane 3 drops its request in the cycle the pointer reaches it.
    step(4'b0011, 32'h99887766, 32'h01010101, 64'h5555, 1'b1, 4'b0001, "drop_lane3");
    for (int c = 0; c < 4; c++) step('0, '0, '0, '0, 1'b1, '0, "drain");

    // Two issues, then reset: the in-flight results must vanish.
    step('1, 32'h13579bdf, 32'h2468ace0, 64'h77, 1'b1, 4'b0010, "pre_rst1");
    step('1, 32'h13579bdf, 32'h2468ace0, 64'h88, 1'b1, 4'b0100, "pre_rst2");
    RST = 1'b1;
    sb_q.delete();
    @(negedge CLK);
    chk("rst_mid_ready", 64'({rnd_ready, req_ready}), 64'h0);
    next_cycle();
    RST = 1'b0; req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk("post_rst", 64'({resp_valid, resp_id, resp_out0, resp_out1, resp_out2, resp_out3}), 64'h0);
      chk("post_rst_idle", 64'({idle, inv_in0, inv_in1}) | inv_r, 64'h10000);
      next_cycle();
    end
    step('1, 32'h40302010, 32'h04030201, 64'h9999, 1'b1, 4'b0001, "rst_next_lane0");
    for (int c = 0; c < 4; c++) step('0, '0, '0, '0, 1'b1, '0, "drain");

    // Exhaustive share sweep on lane 0 at full throughput.
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 256; b++)
        step(4'b0001, 32'(a), 32'(b), {$urandom, $urandom}, 1'b1, 4'b0001, "sweep");
    for (int c = 0; c < 5; c++) step('0, '0, '0, '0, 1'b1, '0, "drain");
    chk("sb_empty", 64'(sb_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inv_share_scheduler.md
# inv_share_scheduler

Round-robin scheduler that shares one two-share-in / four-share-out masked GF(2^8) inversion core (two-stage TI, 64-bit fresh randomness per operation) among N requesters, e.g. S-box lanes and the key schedule. It arbitrates requests, registers the selected shares and a fresh random word into the core, and tracks each operation through the core's fixed pipeline. It returns the four output shares tagged with the requester ID. It sits between the requesters and the inversion core; the core itself is instantiated outside this block.

## Interface
- N, default 4: number of requesters (2..8).
- LAT, default 2: register stages inside the inversion core.
- IDW, default $clog2(N): requester ID width.
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  N  per-requester request.
- req_in0, req_in1  in  8*N  per-requester Boolean shares (lane i in bits 8i+7:8i).
- req_ready  out  N  one-hot grant; handshake on lane i = req_valid[i] & req_ready[i].
- rnd  in  64  fresh randomness word.
- rnd_valid  in  1  rnd holds an unused word.
- rnd_ready  out  1  rnd is consumed this cycle.
- inv_in0, inv_in1  out  8  registered shares to the core.
- inv_r  out  64  registered randomness to the core.
- inv_out0..inv_out3  in  8 each  core output shares.
- resp_valid  out  1  inv_out* carry a result this cycle.
- resp_id  out  IDW  requester that owns the result.
- resp_out0..resp_out3  out  8 each  copies of inv_out0..3; forced to 0 when resp_valid=0.
- idle  out  1  no operation in flight and no issue this cycle.

## Operation
- Arbitration: a priority pointer ptr ∈ [0,N-1] is reset to 0. Each cycle the scheduler grants the first i with req_valid[i]=1, searching from ptr upward with wrap-around. It grants only if rnd_valid=1. After a grant to i, ptr ← (i+1) mod N. With no grant, ptr is held.
- At most one grant per cycle. rnd_ready = |req_ready. req_ready is combinational from req_valid, ptr and rnd_valid, and has no path from resp_*.
- Issue register: on a handshake, inv_in0/inv_in1/inv_r ← granted shares/rnd next edge. On any non-issue cycle they load 0. The core never sees stale shares or reused randomness.
- Randomness is never consumed without an issue. A given rnd word feeds exactly one operation.
- Tracking: a (LAT+1)-deep shift register of {valid, id} is advanced every cycle. The core cannot stall, so there is no output backpressure; requesters must accept resp_valid unconditionally.
- Shares are never recombined inside the block. Per-lane share muxes are one-hot AND-OR, with no XOR between in0 and in1 paths.
- Reset: ptr=0, tracking valids=0, inv_in0=inv_in1=0, inv_r=0, resp_valid=0, resp_id=0, resp_out*=0, idle=1. req_ready=0 and rnd_ready=0 while RST=1. Reset mid-operation discards in-flight operations silently; no response is produced for them.

## Timing
- Handshake at edge k: inv_in*/inv_r valid during cycle k+1. Core result appears during cycle k+1+LAT. resp_valid=1 in that same cycle with resp_id of the granted lane.
- Total latency is LAT+1 cycles (3 by default). Throughput is one operation per cycle.
- Back-to-back grants produce back-to-back responses in grant order.
- idle = 0 if any tracking valid is set or a handshake occurs this cycle.
- Simultaneous request drop and grant: a lane deasserting req_valid in cycle k is not granted in cycle k.

## Structure
- Shared package: none required. IDW is derived locally.
- One sub-module, rr_arbiter, parameterised by N:
  - inputs: req, en, CLK, RST.
  - outputs: one-hot gnt and gnt_id; it holds the pointer.
- Share muxes, issue register and tracking shift register are in the top.

## Test plan
- Single request, lane 2, shares 0x53/0x00, rnd=64'h1: inv_in0=0x53 one cycle after the handshake. resp_valid=1 with resp_id=2 three cycles after the handshake. resp_out XOR equals 0xCA when driven by a golden core.
- All 4 lanes request continuously with rnd_valid=1: grants cycle 0,1,2,3,0,…. Responses appear with ids in the same order, with no gaps.
- rnd_valid=0 for 5 cycles with requests pending: req_ready=0, rnd_ready=0, inv_in*=0. The first grant follows rnd_valid=1 in the same cycle.
- Lanes 1 and 3 requesting, ptr=2: lane 3 is granted first, then lane 1 (wrap).
- RST asserted one cycle after two issues: no resp_valid afterwards, all outputs 0, idle=1. The next grant goes to lane 0.
- Exhaustive sweep with a lane-0 request, in1 0..255 × in0 0..255, random rnd: every response matches X⁻¹ of in0^in1, with 0→0.
